// File: rtl/sauria_tile_sequencer.sv
// Tile sequencer for a SAURIA tile: for each tile it launches the DMA reader, the
// SAURIA core and the DMA writer in turn, with per-phase timeout and abort.
module sauria_tile_sequencer #(
   parameter int TILE_CNT_W     = 16,
   parameter int TIMEOUT_CYCLES = 1048575,
   parameter int TMO_W          = 20
) (
   input  logic                  i_system_clk,
   input  logic                  i_system_rstn,
   input  logic                  i_start,
   input  logic [TILE_CNT_W-1:0] i_num_tiles,
   input  logic                  i_abort,
   input  logic                  i_reader_dmaintr,
   input  logic                  i_sauriaintr,
   input  logic                  i_writer_dmaintr,
   input  logic                  i_intr_clr,
   output logic                  o_reader_start,
   output logic                  o_sauria_start,
   output logic                  o_writer_start,
   output logic                  o_busy,
   output logic [TILE_CNT_W-1:0] o_tile_idx,
   output logic [1:0]            o_status,
   output logic                  o_intr
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RD_START  = 3'd1,
      ST_RD_WAIT   = 3'd2,
      ST_CMP_START = 3'd3,
      ST_CMP_WAIT  = 3'd4,
      ST_WR_START  = 3'd5,
      ST_WR_WAIT   = 3'd6,
      ST_DONE      = 3'd7
   } state_t;

   localparam logic [1:0] STATUS_NONE    = 2'b00;
   localparam logic [1:0] STATUS_DONE    = 2'b01;
   localparam logic [1:0] STATUS_TIMEOUT = 2'b10;
   localparam logic [1:0] STATUS_ABORT   = 2'b11;

   localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 32'sd1);
   localparam logic [TMO_W-1:0]      TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
   localparam logic [TILE_CNT_W-1:0] TILE_ONE = {{(TILE_CNT_W-1){1'b0}}, 1'b1};

   state_t                  state_q, state_d;
   logic [TILE_CNT_W-1:0]   tile_idx_q, tile_idx_d;
   logic [TILE_CNT_W-1:0]   count_q, count_d;
   logic [TMO_W-1:0]        tmo_q, tmo_d;
   logic [1:0]              status_q, status_d;
   logic                    intr_q, intr_d;
   logic                    reader_start_q, reader_start_d;
   logic                    sauria_start_q, sauria_start_d;
   logic                    writer_start_q, writer_start_d;
   logic                    busy_q, busy_d;

   logic                    intr_set;
   logic                    last_tile;
   logic                    tmo_expired;
   logic                    abort_hit;

   // count is never zero while a phase runs, so count-1 cannot wrap
   assign last_tile   = (tile_idx_q == (count_q - TILE_ONE));
   assign tmo_expired = (tmo_q == TMO_LAST);
   assign abort_hit   = i_abort && (state_q != ST_IDLE);

   // Next-state, counters and status/interrupt update
   always_comb begin
      state_d    = state_q;
      tile_idx_d = tile_idx_q;
      count_d    = count_q;
      tmo_d      = tmo_q;
      status_d   = status_q;
      intr_set   = 1'b0;

      if (abort_hit) begin
         state_d  = ST_IDLE;
         status_d = STATUS_ABORT;
         intr_set = 1'b1;
         tmo_d    = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  tile_idx_d = '0;
                  count_d    = i_num_tiles;
                  tmo_d      = '0;
                  if (i_num_tiles != '0) begin
                     state_d  = ST_RD_START;
                     status_d = STATUS_NONE;
                  end else begin
                     state_d  = ST_DONE;
                     status_d = STATUS_DONE;
                     intr_set = 1'b1;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RD_START, ST_RD_WAIT: begin
               if (i_reader_dmaintr) begin
                  state_d = ST_CMP_START;
                  tmo_d   = '0;
               end else if (tmo_expired) begin
                  state_d  = ST_IDLE;
                  status_d = STATUS_TIMEOUT;
                  intr_set = 1'b1;
                  tmo_d    = '0;
               end else begin
                  state_d = ST_RD_WAIT;
                  tmo_d   = tmo_q + TMO_ONE;
               end
            end
            ST_CMP_START, ST_CMP_WAIT: begin
               if (i_sauriaintr) begin
                  state_d = ST_WR_START;
                  tmo_d   = '0;
               end else if (tmo_expired) begin
                  state_d  = ST_IDLE;
                  status_d = STATUS_TIMEOUT;
                  intr_set = 1'b1;
                  tmo_d    = '0;
               end else begin
                  state_d = ST_CMP_WAIT;
                  tmo_d   = tmo_q + TMO_ONE;
               end
            end
            ST_WR_START, ST_WR_WAIT: begin
               if (i_writer_dmaintr) begin
                  tmo_d = '0;
                  if (last_tile) begin
                     state_d  = ST_DONE;
                     status_d = STATUS_DONE;
                     intr_set = 1'b1;
                  end else begin
                     state_d    = ST_RD_START;
                     tile_idx_d = tile_idx_q + TILE_ONE;
                  end
               end else if (tmo_expired) begin
                  state_d  = ST_IDLE;
                  status_d = STATUS_TIMEOUT;
                  intr_set = 1'b1;
                  tmo_d    = '0;
               end else begin
                  state_d = ST_WR_WAIT;
                  tmo_d   = tmo_q + TMO_ONE;
               end
            end
            ST_DONE: begin
               // keep asserting the set so a clear landing in DONE cannot drop it
               state_d  = ST_IDLE;
               intr_set = 1'b1;
            end
            default: begin
               state_d = ST_IDLE;
               tmo_d   = '0;
            end
         endcase
      end
   end

   // Sticky interrupt and Moore outputs derived from the next state
   always_comb begin
      intr_d = intr_q;
      if (intr_set) begin
         intr_d = 1'b1;
      end else if (i_intr_clr) begin
         intr_d = 1'b0;
      end else begin
         intr_d = intr_q;
      end
      reader_start_d = (state_d == ST_RD_START);
      sauria_start_d = (state_d == ST_CMP_START);
      writer_start_d = (state_d == ST_WR_START);
      busy_d         = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge i_system_clk) begin
      if (!i_system_rstn) begin
         state_q        <= ST_IDLE;
         tile_idx_q     <= '0;
         count_q        <= '0;
         tmo_q          <= '0;
         status_q       <= STATUS_NONE;
         intr_q         <= 1'b0;
         reader_start_q <= 1'b0;
         sauria_start_q <= 1'b0;
         writer_start_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         tile_idx_q     <= tile_idx_d;
         count_q        <= count_d;
         tmo_q          <= tmo_d;
         status_q       <= status_d;
         intr_q         <= intr_d;
         reader_start_q <= reader_start_d;
         sauria_start_q <= sauria_start_d;
         writer_start_q <= writer_start_d;
         busy_q         <= busy_d;
      end
   end

   assign o_reader_start = reader_start_q;
   assign o_sauria_start = sauria_start_q;
   assign o_writer_start = writer_start_q;
   assign o_busy         = busy_q;
   assign o_tile_idx     = tile_idx_q;
   assign o_status       = status_q;
   assign o_intr         = intr_q;

endmodule

// File: tb/tb_sauria_tile_sequencer.sv
// Scoreboard bench for sauria_tile_sequencer: stimulus queues expected start pulses
// and job-end records; a forked monitor pops and compares them as the DUT emits them.
module tb_sauria_tile_sequencer;

   localparam int TW   = 4;
   localparam int TMO  = 8;
   localparam int TMW  = 4;

   localparam int K_RD  = 0;
   localparam int K_CMP = 1;
   localparam int K_WR  = 2;
   localparam int K_END = 3;

   logic          clk = 1'b0;
   logic          rstn;
   logic          i_start;
   logic [TW-1:0] i_num_tiles;
   logic          i_abort;
   logic          i_reader_dmaintr;
   logic          i_sauriaintr;
   logic          i_writer_dmaintr;
   logic          i_intr_clr;
   logic          o_reader_start;
   logic          o_sauria_start;
   logic          o_writer_start;
   logic          o_busy;
   logic [TW-1:0] o_tile_idx;
   logic [1:0]    o_status;
   logic          o_intr;

   typedef struct {
      int kind;
      int tile;
      int status;
      int intr;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;

   always #5 clk = ~clk;

   sauria_tile_sequencer #(
      .TILE_CNT_W    (TW),
      .TIMEOUT_CYCLES(TMO),
      .TMO_W         (TMW)
   ) dut (
      .i_system_clk    (clk),
      .i_system_rstn   (rstn),
      .i_start         (i_start),
      .i_num_tiles     (i_num_tiles),
      .i_abort         (i_abort),
      .i_reader_dmaintr(i_reader_dmaintr),
      .i_sauriaintr    (i_sauriaintr),
      .i_writer_dmaintr(i_writer_dmaintr),
      .i_intr_clr      (i_intr_clr),
      .o_reader_start  (o_reader_start),
      .o_sauria_start  (o_sauria_start),
      .o_writer_start  (o_writer_start),
      .o_busy          (o_busy),
      .o_tile_idx      (o_tile_idx),
      .o_status        (o_status),
      .o_intr          (o_intr)
   );

   task automatic chk(input string name, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   task automatic push(input int kind, input int tile, input int status, input int intr);
      ev_t e;
      e.kind = kind; e.tile = tile; e.status = status; e.intr = intr;
      exp_q.push_back(e);
   endtask

   task automatic push_tiles(input int first, input int last);
      for (int t = first; t <= last; t++) begin
         push(K_RD, t, 0, 0);
         push(K_CMP, t, 0, 0);
         push(K_WR, t, 0, 0);
      end
   endtask

   task automatic sb_event(input int kind, input int tile, input int status, input int intr);
      ev_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_errors++;
         $display("FAIL sb_unexpected: got kind %0d tile %0d status %0d intr %0d, expected no event",
                  kind, tile, status, intr);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || (kind != K_END && e.tile != tile) ||
             (kind == K_END && (e.status != status || e.intr != intr))) begin
            n_errors++;
            $display("FAIL sb_event: got kind %0d tile %0d status %0d intr %0d, expected kind %0d tile %0d status %0d intr %0d",
                     kind, tile, status, intr, e.kind, e.tile, e.status, e.intr);
         end
      end
   endtask

   task automatic monitor_loop();
      logic prev_busy;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (o_reader_start === 1'b1) sb_event(K_RD, int'(o_tile_idx), 0, 0);
         if (o_sauria_start === 1'b1) sb_event(K_CMP, int'(o_tile_idx), 0, 0);
         if (o_writer_start === 1'b1) sb_event(K_WR, int'(o_tile_idx), 0, 0);
         if (prev_busy && (o_busy === 1'b0)) sb_event(K_END, 0, int'(o_status), int'(o_intr));
         prev_busy = (o_busy === 1'b1);
      end
   endtask

   task automatic drain_check(input string name);
      repeat (2) @(negedge clk);
      chk(name, exp_q.size(), 0);
   endtask

   task automatic clear_intr();
      @(negedge clk); i_intr_clr = 1'b1;
      @(negedge clk); i_intr_clr = 1'b0;
      chk("intr_clear", int'(o_intr), 0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_busy"},   int'(o_busy), 0);
      chk({tag, "_rd"},     int'(o_reader_start), 0);
      chk({tag, "_cmp"},    int'(o_sauria_start), 0);
      chk({tag, "_wr"},     int'(o_writer_start), 0);
      chk({tag, "_tile"},   int'(o_tile_idx), 0);
      chk({tag, "_status"}, int'(o_status), 0);
      chk({tag, "_intr"},   int'(o_intr), 0);
   endtask

   // Drives a job and answers each start pulse 'dly' cycles later; abort rides on
   // the writer completion of tile 'abort_tile'.
   task automatic run_job(input int num, input int dly, input bit hold_cmp,
                          input int abort_tile, output int cmp_cyc, output int end_cyc);
      int rd_c, cmp_c, wr_c, wr_tile, c;
      rd_c = -1; cmp_c = -1; wr_c = -1; wr_tile = -1;
      cmp_cyc = -1; end_cyc = -1;
      @(negedge clk);
      i_start = 1'b1;
      i_num_tiles = TW'(num);
      @(negedge clk);
      i_start = 1'b0;
      chk("start_latency", int'(o_reader_start), int'(num != 0));
      c = 0;
      while (end_cyc < 0 && c < 400) begin
         if (c > 0) @(negedge clk);
         i_reader_dmaintr = 1'b0; i_sauriaintr = 1'b0; i_writer_dmaintr = 1'b0; i_abort = 1'b0;
         if (o_busy !== 1'b1) begin
            end_cyc = c;
         end else begin
            if (rd_c > 0) begin rd_c--; if (rd_c == 0) begin i_reader_dmaintr = 1'b1; rd_c = -1; end end
            if (cmp_c > 0) begin cmp_c--; if (cmp_c == 0) begin i_sauriaintr = 1'b1; cmp_c = -1; end end
            if (wr_c > 0) begin
               wr_c--;
               if (wr_c == 0) begin
                  i_writer_dmaintr = 1'b1; wr_c = -1;
                  if (wr_tile == abort_tile) i_abort = 1'b1;
               end
            end
            if (o_reader_start === 1'b1) begin
               if (dly == 0) i_reader_dmaintr = 1'b1; else rd_c = dly;
            end
            if (o_sauria_start === 1'b1) begin
               cmp_cyc = c;
               if (!hold_cmp) begin
                  if (dly == 0) i_sauriaintr = 1'b1; else cmp_c = dly;
               end
            end
            if (o_writer_start === 1'b1) begin
               wr_tile = int'(o_tile_idx);
               if (dly == 0) begin
                  i_writer_dmaintr = 1'b1;
                  if (wr_tile == abort_tile) i_abort = 1'b1;
               end else begin
                  wr_c = dly;
               end
            end
         end
         c++;
      end
      chk("job_within_budget", int'(end_cyc >= 0), 1);
      i_reader_dmaintr = 1'b0; i_sauriaintr = 1'b0; i_writer_dmaintr = 1'b0; i_abort = 1'b0;
   endtask

   initial begin
      int cmp_cyc, end_cyc;
      rstn = 1'b0; i_start = 1'b0; i_num_tiles = '0; i_abort = 1'b0;
      i_reader_dmaintr = 1'b0; i_sauriaintr = 1'b0; i_writer_dmaintr = 1'b0; i_intr_clr = 1'b0;
      fork
         monitor_loop();
      join_none

      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rstn = 1'b1;

      // three tiles, completions five cycles after each start
      push_tiles(0, 2);
      push(K_END, 0, 1, 1);
      run_job(3, 5, 1'b0, -1, cmp_cyc, end_cyc);
      chk("three_tiles_last_idx", int'(o_tile_idx), 2);
      chk("three_tiles_status", int'(o_status), 1);
      drain_check("three_tiles_drained");
      clear_intr();

      // zero tiles: straight to DONE
      push(K_END, 0, 1, 1);
      run_job(0, 5, 1'b0, -1, cmp_cyc, end_cyc);
      chk("zero_tiles_end_cycle", end_cyc, 1);
      drain_check("zero_tiles_drained");
      clear_intr();

      // compute completion withheld: timeout after 8 compute cycles
      push(K_RD, 0, 0, 0);
      push(K_CMP, 0, 0, 0);
      push(K_END, 0, 2, 1);
      run_job(1, 5, 1'b1, -1, cmp_cyc, end_cyc);
      chk("timeout_compute_cycles", end_cyc - cmp_cyc, 8);
      drain_check("timeout_drained");
      clear_intr();

      // abort together with writer completion on tile 1 of 4
      push_tiles(0, 1);
      push(K_END, 0, 3, 1);
      run_job(4, 2, 1'b0, 1, cmp_cyc, end_cyc);
      chk("abort_tile_idx", int'(o_tile_idx), 1);
      drain_check("abort_drained");
      clear_intr();

      // spurious writer completion and start while busy, then clear racing DONE
      push_tiles(0, 0);
      push(K_END, 0, 1, 1);
      @(negedge clk); i_start = 1'b1; i_num_tiles = TW'(1);
      @(negedge clk); i_start = 1'b0;
      @(negedge clk); i_writer_dmaintr = 1'b1; i_start = 1'b1; i_num_tiles = TW'(5);
      @(negedge clk); i_writer_dmaintr = 1'b0; i_start = 1'b0;
      chk("spurious_busy", int'(o_busy), 1);
      chk("spurious_no_cmp", int'(o_sauria_start), 0);
      chk("spurious_no_rd", int'(o_reader_start), 0);
      i_reader_dmaintr = 1'b1;
      @(negedge clk); i_reader_dmaintr = 1'b0; i_sauriaintr = 1'b1;
      @(negedge clk); i_sauriaintr = 1'b0; i_writer_dmaintr = 1'b1; i_intr_clr = 1'b1;
      @(negedge clk); i_writer_dmaintr = 1'b0;
      chk("clr_vs_done_status", int'(o_status), 1);
      @(negedge clk); i_intr_clr = 1'b0;
      chk("clr_vs_done_intr", int'(o_intr), 1);
      drain_check("spurious_drained");
      clear_intr();

      // reset in the compute wait phase, completions during reset discarded
      push(K_RD, 0, 0, 0);
      push(K_CMP, 0, 0, 0);
      push(K_END, 0, 0, 0);
      @(negedge clk); i_start = 1'b1; i_num_tiles = TW'(2);
      @(negedge clk); i_start = 1'b0; i_reader_dmaintr = 1'b1;
      @(negedge clk); i_reader_dmaintr = 1'b0;
      @(negedge clk); rstn = 1'b0; i_sauriaintr = 1'b1; i_reader_dmaintr = 1'b1;
      @(negedge clk);
      check_reset_values("midjob_reset");
      rstn = 1'b1; i_sauriaintr = 1'b0; i_reader_dmaintr = 1'b0;
      drain_check("midjob_reset_drained");
      push_tiles(0, 1);
      push(K_END, 0, 1, 1);
      run_job(2, 3, 1'b0, -1, cmp_cyc, end_cyc);
      chk("after_reset_tile_idx", int'(o_tile_idx), 1);
      drain_check("after_reset_drained");
      clear_intr();

      // maximum tile count, completions in the same cycle as each start
      push_tiles(0, 14);
      push(K_END, 0, 1, 1);
      run_job(15, 0, 1'b0, -1, cmp_cyc, end_cyc);
      chk("max_tiles_last_idx", int'(o_tile_idx), 14);
      drain_check("max_tiles_drained");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sauria_tile_sequencer.md
SAURIA_TILE_SEQUENCER -- requirements
Module: sauria_tile_sequencer

Interface
REQ-001 SHALL have parameter TILE_CNT_W, default 16, width of tile count and index.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1048575, max wait cycles per phase before timeout.
REQ-003 SHALL have parameter TMO_W, default 20, timeout counter width; TIMEOUT_CYCLES < 2^TMO_W.
REQ-004 Clocking: one clock, i_system_clk; reset i_system_rstn is synchronous and active-low.
REQ-005 i_system_clk  in  1  sole clock, all logic on rising edge.
REQ-006 i_system_rstn  in  1  synchronous active-low reset.
REQ-007 i_start  in  1  1-cycle pulse, begins a job of i_num_tiles tiles.
REQ-008 i_num_tiles  in  TILE_CNT_W  tile count, sampled only when i_start is accepted.
REQ-009 i_abort  in  1  1-cycle pulse, terminates the running job.
REQ-010 i_reader_dmaintr  in  1  DMA reader completion pulse.
REQ-011 i_sauriaintr  in  1  SAURIA core completion pulse.
REQ-012 i_writer_dmaintr  in  1  DMA writer completion pulse.
REQ-013 i_intr_clr  in  1  clears o_intr.
REQ-014 o_reader_start  out  1  1-cycle pulse, launch DMA reader for current tile.
REQ-015 o_sauria_start  out  1  1-cycle pulse, launch SAURIA compute.
REQ-016 o_writer_start  out  1  1-cycle pulse, launch DMA writer.
REQ-017 o_busy  out  1  high whenever state != IDLE.
REQ-018 o_tile_idx  out  TILE_CNT_W  index of tile in progress (0-based).
REQ-019 o_status  out  2  00 none, 01 done, 10 timeout, 11 aborted; held until next accepted i_start.
REQ-020 o_intr  out  1  sticky completion/error interrupt (control FSM interrupt).

Function
REQ-021 FSM states SHALL be IDLE, RD_START, RD_WAIT, CMP_START, CMP_WAIT, WR_START, WR_WAIT, DONE; all outputs registered/Moore.
REQ-022 IDLE: i_start with i_num_tiles != 0 -> RD_START next cycle, tile_idx=0, latch count, o_status=00; i_num_tiles == 0 -> DONE, no start pulses.
REQ-023 i_start while o_busy SHALL be ignored, no state or count change.
REQ-024 o_reader_start/o_sauria_start/o_writer_start SHALL be high exactly in RD_START/CMP_START/WR_START respectively; each START lasts one cycle.
REQ-025 Latency: i_start in cycle N -> o_reader_start in cycle N+1.
REQ-026 RD_START/RD_WAIT: i_reader_dmaintr -> CMP_START; otherwise RD_START -> RD_WAIT.
REQ-027 CMP_START/CMP_WAIT: i_sauriaintr -> WR_START; otherwise CMP_START -> CMP_WAIT.
REQ-028 WR_START/WR_WAIT: i_writer_dmaintr -> DONE if tile_idx == count-1, else RD_START with tile_idx+1.
REQ-029 Completion pulses not belonging to current phase SHALL be ignored.
REQ-030 Timeout counter SHALL clear on entering each START state, increment each cycle in START/WAIT without completion; reaching TIMEOUT_CYCLES -> IDLE, o_status=10, o_intr=1.
REQ-031 i_abort while busy SHALL win over any same-cycle completion: next state IDLE, o_status=11, o_intr=1, no further start pulses; i_abort in IDLE ignored.
REQ-032 DONE: one cycle, o_status=01, o_intr=1, then IDLE; o_tile_idx holds last value until next start.
REQ-033 o_intr SHALL clear on i_intr_clr; simultaneous set event and i_intr_clr -> o_intr=1 (set wins).
REQ-034 Tile counter arithmetic is TILE_CNT_W unsigned; max count 2^TILE_CNT_W-1 SHALL complete without wrap.

Reset
REQ-035 i_system_rstn=0 at a clock edge SHALL force state IDLE, all start pulses 0, o_busy=0, o_tile_idx=0, o_status=00, o_intr=0, timeout counter 0, regardless of state mid-job.
REQ-036 Completion pulses during reset SHALL be discarded.

Verification
REQ-037 Start num_tiles=3, each completion 5 cycles after its start -> 3x (reader,sauria,writer) pulse order, tile_idx 0,1,2, o_status=01, o_intr=1, o_busy falls.
REQ-038 Start num_tiles=0 -> no start pulses, o_intr=1 and o_status=01 within 2 cycles.
REQ-039 TIMEOUT_CYCLES=8, withhold i_sauriaintr -> IDLE after 8 cycles in compute phase, o_status=10, o_intr=1.
REQ-040 i_abort same cycle as i_writer_dmaintr on tile 1 of 4 -> o_status=11, no further o_reader_start.
REQ-041 Spurious i_writer_dmaintr in RD_WAIT and i_start while busy -> no state change; i_intr_clr with simultaneous DONE -> o_intr stays 1.
REQ-042 Reset asserted in CMP_WAIT -> all outputs at reset values next cycle; new job after reset runs normally.
